ldm_seq: RTL

- Parametrised block-transfer sequencer for LDM/STM in the execute stage.
- Takes a register list and an addressing mode, then issues one memory beat per accepted cycle.
- Each beat carries the register code, the byte offset from the base, and the writeback enable.
- Supplies the hold signal that freezes upstream stages and the final base-writeback offset.
- Its per-beat outputs replace the execute-stage operand-2, memory-valid, writeback-valid and writeback-register-code selections while an LDM/STM is active.

---
 rtl/ldm_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ldm_seq.sv
// Block-transfer sequencer for LDM/STM: walks a register list in ascending order,
// presenting one memory beat per accepted cycle, then reports the base-writeback offset.
module ldm_seq #(
    parameter int NREG       = 16,
    parameter int CODE_W     = $clog2(NREG),
    parameter int BEAT_BYTES = 4,
    parameter int DW         = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NREG-1:0]   i_reg_list,
    input  logic [1:0]        i_pu,
    input  logic              i_is_load,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_hold,
    output logic              o_mem_vld,
    output logic [CODE_W-1:0] o_reg_code,
    output logic [DW-1:0]     o_offset,
    output logic              o_wb_vld,
    output logic              o_last,
    output logic              o_done,
    output logic [DW-1:0]     o_wb_offset
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   rem_list_q, rem_list_d;
    logic [CODE_W:0]   cnt_q, cnt_d;
    logic [DW-1:0]     offset_q, offset_d;
    logic              load_q, load_d;
    logic              up_q, up_d;

    logic [CODE_W:0]   start_cnt;
    logic [DW-1:0]     start_span;
    logic [DW-1:0]     total_span;
    logic [CODE_W-1:0] low_code;
    logic              one_left;
    logic              in_xfer;

    always_comb begin
        start_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            start_cnt = start_cnt + {{CODE_W{1'b0}}, i_reg_list[i]};
        end
        start_span = DW'(start_cnt) * DW'(BEAT_BYTES);
        total_span = DW'(cnt_q) * DW'(BEAT_BYTES);
    end

    // Scan from the top so the lowest set bit is the one left standing.
    always_comb begin
        low_code = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem_list_q[i]) begin
                low_code = CODE_W'(i);
            end
        end
        one_left = (rem_list_q != '0) &&
                   ((rem_list_q & (rem_list_q - NREG'(1))) == '0);
    end

    always_comb begin
        state_d    = state_q;
        rem_list_d = rem_list_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        load_d     = load_q;
        up_d       = up_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rem_list_d = i_reg_list;
                    cnt_d      = start_cnt;
                    load_d     = i_is_load;
                    up_d       = i_pu[0];
                    case (i_pu)
                        2'b01:   offset_d = '0;
                        2'b11:   offset_d = DW'(BEAT_BYTES);
                        2'b00:   offset_d = DW'(BEAT_BYTES) - start_span;
                        default: offset_d = '0 - start_span;
                    endcase
                    state_d = (start_cnt != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (i_flush) begin
                    state_d    = ST_IDLE;
                    rem_list_d = '0;
                    cnt_d      = '0;
                    offset_d   = '0;
                    load_d     = 1'b0;
                    up_d       = 1'b0;
                end else if (!i_stall) begin
                    rem_list_d[low_code] = 1'b0;
                    offset_d = offset_q + DW'(BEAT_BYTES);
                    if (one_left) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                // DONE lasts one cycle whether or not a flush arrives.
                state_d    = ST_IDLE;
                rem_list_d = '0;
                cnt_d      = '0;
                offset_d   = '0;
                load_d     = 1'b0;
                up_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rem_list_q <= '0;
            cnt_q      <= '0;
            offset_q   <= '0;
            load_q     <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_list_q <= rem_list_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            load_q     <= load_d;
            up_q       <= up_d;
        end
    end

    assign in_xfer     = (state_q == ST_XFER);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_hold      = in_xfer;
    assign o_mem_vld   = in_xfer;
    assign o_reg_code  = in_xfer ? low_code : '0;
    assign o_offset    = in_xfer ? offset_q : '0;
    assign o_wb_vld    = in_xfer & load_q;
    assign o_last      = in_xfer & one_left;
    assign o_done      = (state_q == ST_DONE);
    assign o_wb_offset = (state_q == ST_DONE) ? (up_q ? total_span : ('0 - total_span)) : '0;

endmodule
